// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks the register file read port from x0 to x(NUM_REGS-1).
// Each register is emitted as an {addr,data} record on a valid/ready stream.
// Records are snapshots, so later register-file writes do not disturb a
// record that is waiting for its handshake.
module rf_dump_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t state, nxt;
  logic   hs;

  assign hs   = out_valid & out_ready;
  assign busy = (state != IDLE);
  // FIN is entered only after the last handshake cleared out_valid, so done
  // and out_valid can never overlap.
  assign done = (state == FIN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic; abort wins over handshake, start only counts in IDLE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start && !abort) nxt = READ;
      READ: nxt = abort ? IDLE : HOLD;
      HOLD: begin
        if (abort)   nxt = IDLE;
        else if (hs) nxt = (rf_addr == LAST) ? FIN : READ;
      end
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Read address walk and record capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (state != IDLE && abort) begin
      out_valid <= 1'b0;
      rf_addr   <= '0;
    end else begin
      case (state)
        IDLE: if (start) rf_addr <= '0;
        READ: begin
          // rf_data is combinational from rf_addr; a negedge write in this
          // cycle is already visible here.
          out_data  <= rf_data;
          out_addr  <= rf_addr;
          out_valid <= 1'b1;
        end
        HOLD: if (hs) begin
          out_valid <= 1'b0;
          // Stop at the last register; the address never wraps.
          if (rf_addr != LAST) rf_addr <= rf_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Scoreboard bench for rf_dump_reader: expected records are queued from the
// register-file model when a dump starts and popped on every handshake.
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [4:0]  rf_addr, out_addr;
  logic [31:0] rf_data, out_data;
  logic        out_valid, busy, done;

  logic        start8 = 1'b0, ready8 = 1'b0;
  logic [2:0]  rf_addr8, out_addr8;
  logic [31:0] rf_data8, out_data8;
  logic        out_valid8, busy8, done8;

  logic [31:0] rf  [32];
  logic [31:0] rf8 [8];

  typedef struct packed {logic [4:0] a; logic [31:0] d;} rec_t;
  rec_t q[$], q8[$];
  rec_t mr, mr8;

  int nvec = 0, nerr = 0, nrec = 0, nrec8 = 0, cyc = 0;

  assign rf_data  = rf[rf_addr];
  assign rf_data8 = rf8[rf_addr8];

  always #5 clk = ~clk;

  rf_dump_reader #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done));

  rf_dump_reader #(.ADDR_W(3), .DATA_W(32), .NUM_REGS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(1'b0),
    .rf_addr(rf_addr8), .rf_data(rf_data8),
    .out_valid(out_valid8), .out_ready(ready8),
    .out_addr(out_addr8), .out_data(out_data8),
    .busy(busy8), .done(done8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  // Queue the expected dump from the current model and pulse start.
  task automatic go();
    rec_t r;
    for (int i = 0; i < 32; i++) begin
      r.a = 5'(i); r.d = rf[i];
      q.push_back(r);
    end
    start = 1'b1; tick(); start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 300) tick();
    chk("done_seen", done, 1'b1);
  endtask

  // Advance until record a is presented, then drop ready so it is held.
  task automatic wait_rec(input int a);
    int n = 0;
    while (!(out_valid && out_addr == 5'(a)) && n < 200) begin tick(); n++; end
    chk("rec_reached", out_addr, 5'(a));
    ready = 1'b0;
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) if (rst_n) begin
    if (out_valid && ready) begin
      if (q.size() == 0) chk("extra_rec", 1'b1, 1'b0);
      else begin
        mr = q.pop_front();
        chk("rec_addr", out_addr, mr.a);
        chk("rec_data", out_data, mr.d);
        nrec++;
      end
    end
    if (done) chk("done_excl", out_valid, 1'b0);
  end

  always @(negedge clk) if (rst_n) begin
    if (out_valid8 && ready8) begin
      if (q8.size() == 0) chk("extra_rec8", 1'b1, 1'b0);
      else begin
        mr8 = q8.pop_front();
        chk("rec8_addr", out_addr8, mr8.a);
        chk("rec8_data", out_data8, mr8.d);
        nrec8++;
      end
    end
    if (done8) chk("done8_excl", out_valid8, 1'b0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] old;
    rec_t r;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0; rf[1] = 32'h11111111; rf[31] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) rf8[i] = $urandom;
    rf8[0] = 32'h0;

    // Reset state
    #12;
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // start+abort together in IDLE: stay idle
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("sa_idle_busy", busy, 0);

    // 1: full dump, ready held high
    ready = 1'b1; n0 = nrec;
    go();
    wait_done();
    chk("t1_done_cyc", cyc, 65);
    chk("t1_nrec", nrec - n0, 32);
    chk("t1_q_empty", q.size(), 0);
    tick();
    chk("t1_busy_fall", busy, 0);
    chk("t1_done_fall", done, 0);

    // 2: backpressure at record 5
    ready = 1'b1; n0 = nrec;
    go();
    wait_rec(5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_valid", out_valid, 1);
      chk("t2_addr", out_addr, 5);
      chk("t2_data", out_data, rf[5]);
    end
    ready = 1'b1;
    tick(); chk("t2_gap", out_valid, 0);
    tick(); chk("t2_next_v", out_valid, 1); chk("t2_next_a", out_addr, 6);
    wait_done();
    chk("t2_nrec", nrec - n0, 32);

    // 3: snapshot while record 7 is held
    tick();
    ready = 1'b1; n0 = nrec;
    go();
    wait_rec(7);
    old = rf[7];
    @(negedge clk); rf[7] = 32'hCAFEF00D;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_snap", out_data, old);
      tick();
    end
    ready = 1'b1;
    wait_done();
    chk("t3_nrec", nrec - n0, 32);

    // 4: abort at record 12 with ready low, then restart
    tick();
    ready = 1'b1; n0 = nrec;
    go();
    wait_rec(12);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_rf_addr", rf_addr, 0);
    chk("t4_nrec", nrec - n0, 12);
    q.delete();
    tick(); chk("t4_no_done", done, 0);
    ready = 1'b1; n0 = nrec;
    go();
    chk("t4_restart_addr", rf_addr, 0);
    wait_done();
    chk("t4_restart_cyc", cyc, 65);
    chk("t4_restart_nrec", nrec - n0, 32);

    // 5: start pulsed while busy is ignored
    tick();
    ready = 1'b1; n0 = nrec;
    go();
    repeat (10) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done();
    chk("t5_done_cyc", cyc, 65);
    chk("t5_nrec", nrec - n0, 32);

    // 5b: async reset mid-dump
    tick();
    go();
    repeat (9) tick();
    rst_n = 1'b0; #1;
    chk("t5r_valid", out_valid, 0);
    chk("t5r_busy", busy, 0);
    chk("t5r_done", done, 0);
    chk("t5r_rf_addr", rf_addr, 0);
    chk("t5r_addr", out_addr, 0);
    chk("t5r_data", out_data, 0);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("t5r_idle", busy, 0);

    // 6: NUM_REGS=8 instance
    ready8 = 1'b1; n0 = nrec8;
    for (int i = 0; i < 8; i++) begin
      r.a = 5'(i); r.d = rf8[i];
      q8.push_back(r);
    end
    start8 = 1'b1; tick(); start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 100) tick();
    chk("t6_done_seen", done8, 1);
    chk("t6_done_cyc", cyc, 17);
    chk("t6_nrec", nrec8 - n0, 8);
    tick();
    chk("t6_busy_fall", busy8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
